// File: rtl/ahb3lite_imem_responder.sv
// AHB3-Lite read-only instruction-memory responder for a fetch port.
// Returns a sourced instruction per fetch after programmable wait states and logs completed fetches.
module ahb3lite_imem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0001_0000,
  parameter int          LOG_DEPTH  = 8,
  parameter logic [31:0] RESET_DATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [31:0] src_instr_i,
  input  logic [3:0]  wait_cfg_i,
  output logic        log_valid_o,
  output logic [31:0] log_addr_o,
  output logic [31:0] log_instr_o,
  input  logic        log_ready_i,
  output logic        log_full_o,
  output logic        log_overflow_o
);

  // state | meaning
  // IDLE  | no data phase pending, zero-wait OKAY
  // WAIT  | inserting wait states, cnt counts down to 1
  // DONE  | OKAY data phase with latched instruction, log push
  // ERR1  | first ERROR cycle (HREADYOUT low)
  // ERR2  | second ERROR cycle, new accepts ignored
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  localparam int AW = $clog2(LOG_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(LOG_DEPTH);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load;
  logic [31:0] addr_q, instr_q, rdata_q;
  logic        accept, illegal;
  logic [32:0] addr_ext, win_lo, win_hi;

  assign accept   = HSEL & HREADY & HTRANS[1];
  // 33-bit window bounds so a window ending exactly at 2^32 stays legal
  assign addr_ext = {1'b0, HADDR};
  assign win_lo   = {1'b0, BASE_ADDR};
  assign win_hi   = {1'b0, BASE_ADDR} + {1'b0, MEM_SIZE};
  assign illegal  = HWRITE
                  | (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                  | (addr_ext < win_lo)
                  | (addr_ext >= win_hi);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          load = 1'b1;
          if (illegal)                 state_d = S_ERR1;
          else if (wait_cfg_i == 4'd0) state_d = S_DONE;
          else begin
            state_d = S_WAIT;
            cnt_d   = wait_cfg_i;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      instr_q <= 32'd0;
      rdata_q <= RESET_DATA;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q  <= HADDR;
        instr_q <= src_instr_i;
      end
      if (state_q == S_DONE) rdata_q <= instr_q;
    end
  end

  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = (state_q == S_DONE) ? instr_q : rdata_q;

  logic [63:0]   log_mem [LOG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, push_ok;

  assign push    = (state_q == S_DONE);
  assign pop     = log_valid_o & log_ready_i;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push & (!log_full_o | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      log_overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (push & !push_ok) log_overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) log_mem[wr_ptr_q] <= {addr_q, instr_q};
  end

  assign log_valid_o = (count_q != '0);
  assign log_full_o  = (count_q == CNT_FULL);
  assign log_addr_o  = log_mem[rd_ptr_q][63:32];
  assign log_instr_o = log_mem[rd_ptr_q][31:0];

endmodule

// File: tb/tb_ahb3lite_imem_responder.sv
// Directed bench for ahb3lite_imem_responder: inputs driven and outputs sampled on the falling edge.
module tb_ahb3lite_imem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] src_instr_i;
  logic [3:0]  wait_cfg_i;
  logic        log_valid_o;
  logic [31:0] log_addr_o;
  logic [31:0] log_instr_o;
  logic        log_ready_i;
  logic        log_full_o;
  logic        log_overflow_o;

  int checks = 0;
  int errors = 0;
  int nlow;

  always #5 clk = ~clk;

  // single-slave bus: bus HREADY is this slave's HREADYOUT
  ahb3lite_imem_responder dut (
    .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADYOUT), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .src_instr_i(src_instr_i),
    .wait_cfg_i(wait_cfg_i), .log_valid_o(log_valid_o), .log_addr_o(log_addr_o),
    .log_instr_o(log_instr_o), .log_ready_i(log_ready_i), .log_full_o(log_full_o),
    .log_overflow_o(log_overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] src,
                       input logic [3:0] w, input logic wr, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = tr; HADDR = a; src_instr_i = src;
    wait_cfg_i = w; HWRITE = wr; HSIZE = sz;
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; log_ready_i = 1'b1;
    HADDR = '0; src_instr_i = '0; wait_cfg_i = '0; HSIZE = 3'd2;
    idle();
    step(); step();
    rst_n = 1'b1;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'h0000_0013);
    chk("rst_log_valid", 32'(log_valid_o), 32'd0);
    chk("rst_log_full", 32'(log_full_o), 32'd0);
    chk("rst_overflow", 32'(log_overflow_o), 32'd0);

    // zero-wait fetch
    drive(2'd2, 32'h200, 32'h0010_0093, 4'd0, 1'b0, 3'd2);
    step(); idle();
    chk("t1_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("t1_hresp", 32'(HRESP), 32'd0);
    chk("t1_hrdata", HRDATA, 32'h0010_0093);
    step();
    chk("t1_log_valid", 32'(log_valid_o), 32'd1);
    chk("t1_log_addr", log_addr_o, 32'h200);
    chk("t1_log_instr", log_instr_o, 32'h0010_0093);
    step();
    chk("t1_log_popped", 32'(log_valid_o), 32'd0);
    chk("t1_hrdata_hold", HRDATA, 32'h0010_0093);

    // three wait states
    drive(2'd2, 32'h204, 32'h0020_0113, 4'd3, 1'b0, 3'd2);
    step(); idle();
    nlow = 0;
    while (HREADYOUT == 1'b0 && nlow < 20) begin nlow++; step(); end
    chk("t2_low_cycles", 32'(nlow), 32'd3);
    chk("t2_hrdata", HRDATA, 32'h0020_0113);
    chk("t2_log_valid_in_done", 32'(log_valid_o), 32'd0);
    step();
    chk("t2_log_addr", log_addr_o, 32'h204);
    chk("t2_log_instr", log_instr_o, 32'h0020_0113);

    // back-to-back pipelined fetches
    drive(2'd2, 32'h200, 32'h0030_0193, 4'd0, 1'b0, 3'd2);
    step();
    chk("t3_done0", HRDATA, 32'h0030_0193);
    drive(2'd3, 32'h204, 32'h0040_0213, 4'd0, 1'b0, 3'd2);
    step();
    chk("t3_done1", HRDATA, 32'h0040_0213);
    chk("t3_done1_rdy", 32'(HREADYOUT), 32'd1);
    chk("t3_log0", log_addr_o, 32'h200);
    drive(2'd3, 32'h208, 32'h0050_0293, 4'd0, 1'b0, 3'd2);
    step(); idle();
    chk("t3_done2", HRDATA, 32'h0050_0293);
    chk("t3_log1", log_addr_o, 32'h204);
    step();
    chk("t3_log2", log_addr_o, 32'h208);
    chk("t3_log2_instr", log_instr_o, 32'h0050_0293);
    step();
    chk("t3_log_empty", 32'(log_valid_o), 32'd0);

    // write -> ERROR, new accept in ERR2 ignored
    drive(2'd2, 32'h200, 32'h1111_1111, 4'd0, 1'b1, 3'd2);
    step(); idle();
    chk("t4w_err1_rdy", 32'(HREADYOUT), 32'd0);
    chk("t4w_err1_resp", 32'(HRESP), 32'd1);
    chk("t4w_hrdata_hold", HRDATA, 32'h0050_0293);
    step();
    chk("t4w_err2_rdy", 32'(HREADYOUT), 32'd1);
    chk("t4w_err2_resp", 32'(HRESP), 32'd1);
    drive(2'd2, 32'h20C, 32'hDEAD_BEEF, 4'd0, 1'b0, 3'd2);
    step(); idle();
    chk("t4w_idle_resp", 32'(HRESP), 32'd0);
    chk("t4w_ignored_hrdata", HRDATA, 32'h0050_0293);
    step();
    chk("t4w_no_log", 32'(log_valid_o), 32'd0);

    // out-of-window read
    drive(2'd2, 32'h0001_0000, 32'h2222_2222, 4'd0, 1'b0, 3'd2);
    step(); idle();
    chk("t4r_err1_rdy", 32'(HREADYOUT), 32'd0);
    chk("t4r_err1_resp", 32'(HRESP), 32'd1);
    step();
    chk("t4r_err2_rdy", 32'(HREADYOUT), 32'd1);
    chk("t4r_err2_resp", 32'(HRESP), 32'd1);
    step();
    chk("t4r_idle_resp", 32'(HRESP), 32'd0);
    chk("t4r_no_log", 32'(log_valid_o), 32'd0);

    // misaligned word, illegal size, then last legal word of the window
    drive(2'd2, 32'h202, 32'h3333_3333, 4'd0, 1'b0, 3'd2);
    step(); idle();
    chk("t4m_err1_resp", 32'(HRESP), 32'd1);
    step(); step();
    drive(2'd2, 32'h200, 32'h3434_3434, 4'd0, 1'b0, 3'd3);
    step(); idle();
    chk("t4s_err1_resp", 32'(HRESP), 32'd1);
    step(); step();
    drive(2'd2, 32'h0000_FFFC, 32'h4444_4444, 4'd0, 1'b0, 3'd2);
    step(); idle();
    chk("t4b_top_resp", 32'(HRESP), 32'd0);
    chk("t4b_top_hrdata", HRDATA, 32'h4444_4444);
    step();
    chk("t4b_top_log", log_addr_o, 32'h0000_FFFC);
    step();

    // overflow: nine fetches, consumer stalled
    log_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(2'd2, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'd0, 1'b0, 3'd2);
      step();
    end
    idle();
    chk("t5_full_after8", 32'(log_full_o), 32'd1);
    chk("t5_no_ovf_yet", 32'(log_overflow_o), 32'd0);
    step();
    chk("t5_overflow", 32'(log_overflow_o), 32'd1);
    chk("t5_still_full", 32'(log_full_o), 32'd1);
    chk("t5_head_addr", log_addr_o, 32'h300);
    chk("t5_head_instr", log_instr_o, 32'hA000_0000);
    step();
    chk("t5_head_stable", log_addr_o, 32'h300);

    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(log_valid_o), 32'd0);
    chk("t5_rst_ovf", 32'(log_overflow_o), 32'd0);
    step();
    rst_n = 1'b1;

    // refill, then push and pop together while full
    for (int i = 0; i < 8; i++) begin
      drive(2'd2, 32'h500 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'd0, 1'b0, 3'd2);
      step();
    end
    idle();
    step();
    chk("t6_full", 32'(log_full_o), 32'd1);
    drive(2'd2, 32'h400, 32'hC000_0000, 4'd0, 1'b0, 3'd2);
    step(); idle();
    log_ready_i = 1'b1;
    step();
    log_ready_i = 1'b0;
    chk("t6_still_full", 32'(log_full_o), 32'd1);
    chk("t6_no_ovf", 32'(log_overflow_o), 32'd0);
    chk("t6_head_next", log_addr_o, 32'h504);

    // reset asserted during WAIT
    drive(2'd2, 32'h410, 32'hD000_0000, 4'd5, 1'b0, 3'd2);
    step(); idle();
    chk("t6_wait_low", 32'(HREADYOUT), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", 32'(HREADYOUT), 32'd1);
    chk("t6_rst_resp", 32'(HRESP), 32'd0);
    chk("t6_rst_hrdata", HRDATA, 32'h0000_0013);
    chk("t6_rst_valid", 32'(log_valid_o), 32'd0);
    chk("t6_rst_full", 32'(log_full_o), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t6_post_rst_no_log", 32'(log_valid_o), 32'd0);
    chk("t6_post_rst_rdy", 32'(HREADYOUT), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb3lite_imem_responder.md
Name: ahb3lite_imem_responder

Overview:
AHB3-Lite read-only instruction-memory slave for the fetch port of riscv_top_ahb3lite.
- Returns an instruction word, supplied from a free or driven source input, for each accepted fetch.
- Inserts a configurable number of wait states per fetch.
- Returns ERROR on illegal accesses.
- Logs every OKAY-completed fetch (address, instruction) into a FIFO. The retirement-side ISA checker compares this log against instructions reaching WB.

Parameters:
BASE_ADDR, 32'h0000_0000, lowest legal fetch byte address
MEM_SIZE, 32'h0001_0000, legal window size in bytes; legal window is [BASE_ADDR, BASE_ADDR+MEM_SIZE)
LOG_DEPTH, 8, fetch-log FIFO entries (power of 2, >=2)
RESET_DATA, 32'h0000_0013, HRDATA value after reset (NOP)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  address-phase address
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  in  1  write indicator
HSIZE  in  3  transfer size
HREADY  in  1  bus-level ready (previous data phase done)
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
src_instr_i  in  32  instruction to return; sampled at address-phase accept
wait_cfg_i  in  4  wait states for this fetch; sampled at accept
log_valid_o  out  1  log head valid
log_addr_o  out  32  logged fetch address
log_instr_o  out  32  logged instruction
log_ready_i  in  1  consumer pops head when log_valid_o & log_ready_i
log_full_o  out  1  FIFO holds LOG_DEPTH entries
log_overflow_o  out  1  sticky; a push was dropped

Behaviour:
- Reset, rst_n asynchronous active-low, clock clk:
  - State=IDLE, HREADYOUT=1, HRESP=0, HRDATA=RESET_DATA.
  - FIFO empty: log_valid_o=0, log_full_o=0, log_overflow_o=0.
  - Assertion mid-transfer aborts the transfer. No log push occurs.
- Accept condition: HSEL & HREADY & HTRANS[1]. BUSY, IDLE or unselected transfers get a zero-wait OKAY data phase and no log entry.
- At accept, latch HADDR, src_instr_i and wait_cfg_i. Classify the access as illegal if any of:
  - HWRITE=1;
  - HSIZE>2;
  - misaligned for HSIZE (HSIZE=1 needs HADDR[0]=0; HSIZE=2 needs HADDR[1:0]=0);
  - HADDR outside the legal window. Window compare is done in 33-bit arithmetic, so BASE_ADDR+MEM_SIZE=2^32 is legal.
- State machine (data phase):
  - IDLE: on a legal accept with wait_cfg_i=0, go to DONE; with wait_cfg_i=N>0, go to WAIT with cnt=N. On an illegal accept, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0, cnt decrements each cycle. At cnt=1, go to DONE. Exactly N low cycles.
  - DONE: HREADYOUT=1, HRESP=0, HRDATA=latched instruction. The log push occurs this cycle. A new accept in this cycle (pipelined address phase) follows the IDLE transition rules. Otherwise return to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Next state is ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No log push. A new accept in this cycle is ignored, because the master cancels on ERROR. Next state is IDLE.
- HRDATA holds its last value outside DONE. The full word is always returned regardless of HSIZE.
- Log FIFO:
  - Push {latched addr, latched instr} in each DONE cycle.
  - Pop when log_valid_o & log_ready_i. Head outputs are stable while log_valid_o & !log_ready_i.
  - Push while full without a simultaneous pop: entry dropped, log_overflow_o set (cleared only by reset).
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: no bypass. The entry appears next cycle.
  - Pointers wrap modulo LOG_DEPTH. Count width is log2(LOG_DEPTH)+1.

Test Plan:
- Reset, then NONSEQ read 0x200, src=0x00100093, wait=0 → next cycle HREADYOUT=1, HRESP=0, HRDATA=0x00100093; log head = (0x200, 0x00100093).
- NONSEQ 0x204 with wait=3 → HREADYOUT low for exactly 3 cycles, then HRDATA=src, one log entry.
- Back-to-back SEQ 0x200/0x204/0x208, wait=0, log_ready_i=1 → three DONE cycles in consecutive cycles; log order 0x200, 0x204, 0x208.
- Write to 0x200, and separately a read of 0x0001_0000 → HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; no log push; state returns to IDLE.
- log_ready_i=0 and 9 fetches with LOG_DEPTH=8 → log_full_o=1 after 8; 9th dropped, log_overflow_o=1; head still the first fetch.
- FIFO full, fetch completes while log_ready_i=1 → count stays 8, log_overflow_o stays 0. Then assert rst_n=0 during WAIT → HREADYOUT=1 immediately, FIFO empty.
